// File: rtl/ste_jagpad_if.sv
// CPU register-bus bundle for the STE Jaguar-pad port block at $FF9200/$FF9202.
interface ste_jagpad_if;
  logic [15:0] din;
  logic        sel;
  logic [4:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [15:0] dout;

  modport master (output din, sel, addr, uds, lds, rw, input dout);
  modport slave  (input din, sel, addr, uds, lds, rw, output dout);
endinterface

// File: rtl/ste_jagpad.sv
// STE enhanced joystick port with Jaguar-pad matrix emulation for two 21-button pads.
// Optional button debounce is compiled in with `define STE_JAGPAD_DEBOUNCE_EN.
module ste_jagpad #(
  parameter int DB_PRESCALE = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  ste_jagpad_if.slave   bus,
  input  logic [20:0]   joy_a,
  input  logic [20:0]   joy_b
);

  logic [7:0]  r_sel;
  logic [41:0] r_sync_p0;
  logic [41:0] r_sync_p1;
  logic [41:0] w_btn;
  logic [11:0] r_row_p2;
  logic        w_sel_wr;
  logic        w_unused;

  assign w_unused = ^{bus.uds, bus.din[15:8]};

  // Active-low {B1, B0, dir[3:0]} for one port; selected columns wired-AND together.
  function automatic logic [5:0] f_matrix(input logic [3:0] col_n, input logic [20:0] b);
    logic [5:0] r;
    r = '1;
    if (!col_n[0]) r &= ~{b[4], b[7], b[3],  b[2],  b[1],  b[0]};
    if (!col_n[1]) r &= ~{b[5], 1'b0, b[10], b[13], b[16], b[19]};
    if (!col_n[2]) r &= ~{b[6], 1'b0, b[11], b[14], b[17], b[9]};
    if (!col_n[3]) r &= ~{b[8], 1'b0, b[12], b[15], b[18], b[20]};
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizer, port B in the upper half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= {joy_b, joy_a};
      r_sync_p1 <= r_sync_p0;
    end
  end

`ifdef STE_JAGPAD_DEBOUNCE_EN
  logic [DB_PRESCALE-1:0] r_presc;
  logic [41:0]            r_db;
  logic [1:0]             r_cnt [42];
  logic                   w_tick;

  assign w_tick = &r_presc;

  // A button must disagree on three consecutive ticks before it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_db    <= '0;
      for (int i = 0; i < 42; i++) r_cnt[i] <= 2'd0;
    end else if (clk_en) begin
      r_presc <= r_presc + {{(DB_PRESCALE-1){1'b0}}, 1'b1};
      if (w_tick) begin
        for (int i = 0; i < 42; i++) begin
          if (r_sync_p1[i] != r_db[i]) begin
            if (r_cnt[i] == 2'd2) begin
              r_db[i]  <= r_sync_p1[i];
              r_cnt[i] <= 2'd0;
            end else begin
              r_cnt[i] <= r_cnt[i] + 2'd1;
            end
          end else begin
            r_cnt[i] <= 2'd0;
          end
        end
      end
    end
  end

  assign w_btn = r_db;
`else
  logic [DB_PRESCALE-1:0] w_unused_presc;
  assign w_unused_presc = '0;
  assign w_btn = r_sync_p1;
`endif

  assign w_sel_wr = bus.sel && !bus.rw && bus.lds && (bus.addr == 5'h01);

  // Stage p2: row register samples the matrix with the pre-write select value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel    <= 8'hFF;
      r_row_p2 <= '1;
    end else if (clk_en) begin
      if (w_sel_wr) r_sel <= bus.din[7:0];
      r_row_p2 <= {f_matrix(r_sel[7:4], w_btn[41:21]), f_matrix(r_sel[3:0], w_btn[20:0])};
    end
  end

  always_comb begin
    bus.dout = 16'h0000;
    if (bus.sel && bus.rw) begin
      case (bus.addr)
        5'h00:   bus.dout = {12'hFFF, r_row_p2[11:10], r_row_p2[5:4]};
        5'h01:   bus.dout = {r_row_p2[9:6], r_row_p2[3:0], r_sel};
        default: bus.dout = 16'h0000;
      endcase
    end
  end

endmodule
